// File: rtl/bilinear_coord_gen.sv
`default_nettype none
// ============================================================================
//  Module   : bilinear_coord_gen
//  Purpose  : Frame-level source-coordinate generator for the bilinear
//             scaler. Rasters the destination frame and emits, for every
//             destination pixel, the four clamped source neighbour indices
//             and the u/v fractional weights. Uses incremental accumulators
//             instead of per-pixel multipliers. Output is a registered
//             valid/ready stream.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i, rst_n_i          clock, asynchronous active-low reset
//    start_i                 frame start pulse (only honoured in IDLE)
//    align_mode_i            0 normal, 1 centre-aligned mapping
//    dest_width_i/height_i   destination frame size
//    src_width_i/height_i    source frame size (clamp limits)
//    scale_factorx_i/y_i     unsigned fixed-point src/dest ratios
//    ready_i                 downstream accepts current bundle
//    valid_o                 bundle valid
//    busy_o, done_o          frame in progress / one-cycle completion pulse
//    destx_o, desty_o        destination coordinate of the bundle
//    srcx0_o..srcy1_o        clamped neighbour indices
//    srcx_fix_o, srcy_fix_o  weights u and v
//    sol_o, eof_o            first pixel of row / last pixel of frame
// ============================================================================
module bilinear_coord_gen #(
  parameter int INDEX_WIDTH = 11,
  parameter int INT_WIDTH   = 8,
  parameter int FIX_WIDTH   = 12
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           start_i,
  input  logic                           align_mode_i,
  input  logic [INDEX_WIDTH-1:0]         dest_width_i,
  input  logic [INDEX_WIDTH-1:0]         dest_height_i,
  input  logic [INDEX_WIDTH-1:0]         src_width_i,
  input  logic [INDEX_WIDTH-1:0]         src_height_i,
  input  logic [INT_WIDTH+FIX_WIDTH-1:0] scale_factorx_i,
  input  logic [INT_WIDTH+FIX_WIDTH-1:0] scale_factory_i,
  input  logic                           ready_i,
  output logic                           valid_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [INDEX_WIDTH-1:0]         destx_o,
  output logic [INDEX_WIDTH-1:0]         desty_o,
  output logic [INDEX_WIDTH-1:0]         srcx0_o,
  output logic [INDEX_WIDTH-1:0]         srcx1_o,
  output logic [INDEX_WIDTH-1:0]         srcy0_o,
  output logic [INDEX_WIDTH-1:0]         srcy1_o,
  output logic [FIX_WIDTH-1:0]           srcx_fix_o,
  output logic [FIX_WIDTH-1:0]           srcy_fix_o,
  output logic                           sol_o,
  output logic                           eof_o
);

  localparam int c_acc_w   = INDEX_WIDTH + FIX_WIDTH + 1;
  localparam int c_scale_w = INT_WIDTH + FIX_WIDTH;
  localparam int c_clamp_w = 2 * INDEX_WIDTH + FIX_WIDTH;

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_load = 2'd1;
  localparam logic [1:0] c_run  = 2'd2;
  localparam logic [1:0] c_done = 2'd3;

  // 0.5 in accumulator format, used to shift centre-aligned sampling back
  localparam logic signed [c_acc_w-1:0] c_half =
    {{(c_acc_w-FIX_WIDTH){1'b0}}, 1'b1, {(FIX_WIDTH-1){1'b0}}};

  // --------------------------------------------------------------------------
  // Per-axis clamp: returns {idx0, idx1, fix}. Negative positions pin to the
  // first source pixel; positions at or beyond the last pixel pin to it with
  // zero weight so the right/bottom neighbour is never out of range.
  // --------------------------------------------------------------------------
  function automatic logic [c_clamp_w-1:0] clamp_axis(
    input logic signed [c_acc_w-1:0] acc,
    input logic [INDEX_WIDTH-1:0]    n
  );
    logic [INDEX_WIDTH-1:0] ip;
    logic [INDEX_WIDTH-1:0] last;
    ip   = acc[c_acc_w-2:FIX_WIDTH];
    last = n - 1'b1;
    if (acc[c_acc_w-1]) begin
      return '0;
    end else if (ip >= last) begin
      return {last, last, {FIX_WIDTH{1'b0}}};
    end else begin
      return {ip, ip + 1'b1, acc[FIX_WIDTH-1:0]};
    end
  endfunction

  // Latched frame configuration
  logic                   r_align;
  logic [INDEX_WIDTH-1:0] r_dw;
  logic [INDEX_WIDTH-1:0] r_dh;
  logic [INDEX_WIDTH-1:0] r_sw;
  logic [INDEX_WIDTH-1:0] r_sh;
  logic [c_scale_w-1:0]   r_sx;
  logic [c_scale_w-1:0]   r_sy;

  // Raster position and accumulators of the next pixel to be issued
  logic [INDEX_WIDTH-1:0]      r_cx;
  logic [INDEX_WIDTH-1:0]      r_cy;
  logic signed [c_acc_w-1:0]   r_acc_x;
  logic signed [c_acc_w-1:0]   r_acc_y;
  logic                        r_more;

  // Output bundle registers
  logic                   r_valid;
  logic [INDEX_WIDTH-1:0] r_destx;
  logic [INDEX_WIDTH-1:0] r_desty;
  logic [INDEX_WIDTH-1:0] r_srcx0;
  logic [INDEX_WIDTH-1:0] r_srcx1;
  logic [INDEX_WIDTH-1:0] r_srcy0;
  logic [INDEX_WIDTH-1:0] r_srcy1;
  logic [FIX_WIDTH-1:0]   r_fx;
  logic [FIX_WIDTH-1:0]   r_fy;
  logic                   r_sol;
  logic                   r_eof;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;

  logic signed [c_acc_w-1:0] w_sx_ext;
  logic signed [c_acc_w-1:0] w_sy_ext;
  logic signed [c_acc_w-1:0] w_init_x;
  logic signed [c_acc_w-1:0] w_init_y;
  logic [c_clamp_w-1:0]      w_clx;
  logic [c_clamp_w-1:0]      w_cly;
  logic                      w_last_x;
  logic                      w_last_y;
  logic                      w_adv;
  logic                      w_frame_end;
  logic                      w_busy;
  logic                      w_done;

  assign w_sx_ext = $signed({{(c_acc_w-c_scale_w){1'b0}}, r_sx});
  assign w_sy_ext = $signed({{(c_acc_w-c_scale_w){1'b0}}, r_sy});

  // Centre mode: src = (dst + 0.5)*s - 0.5, so pixel 0 starts at s/2 - 0.5
  assign w_init_x = r_align
                  ? $signed({{(c_acc_w-c_scale_w){1'b0}}, (r_sx >> 1)}) - c_half
                  : '0;
  assign w_init_y = r_align
                  ? $signed({{(c_acc_w-c_scale_w){1'b0}}, (r_sy >> 1)}) - c_half
                  : '0;

  assign w_clx = clamp_axis(r_acc_x, r_sw);
  assign w_cly = clamp_axis(r_acc_y, r_sh);

  assign w_last_x = (r_cx == r_dw - 1'b1);
  assign w_last_y = (r_cy == r_dh - 1'b1);

  // Load a new bundle when the output slot is empty or being consumed
  assign w_adv       = (r_state == c_run) && r_more && (!r_valid || ready_i);
  assign w_frame_end = r_valid && ready_i && r_eof;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle: if (start_i) w_state_nxt = c_load;
      c_load: w_state_nxt = ((r_dw == '0) || (r_dh == '0)) ? c_done : c_run;
      c_run:  if (w_frame_end) w_state_nxt = c_done;
      c_done: w_state_nxt = c_idle;
      default: w_state_nxt = c_idle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      c_load,
      c_run:  w_busy = 1'b1;
      c_done: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
        w_done = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Configuration latch
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_align <= 1'b0;
      r_dw    <= '0;
      r_dh    <= '0;
      r_sw    <= '0;
      r_sh    <= '0;
      r_sx    <= '0;
      r_sy    <= '0;
    end else if ((r_state == c_idle) && start_i) begin
      r_align <= align_mode_i;
      r_dw    <= dest_width_i;
      r_dh    <= dest_height_i;
      r_sw    <= src_width_i;
      r_sh    <= src_height_i;
      r_sx    <= scale_factorx_i;
      r_sy    <= scale_factory_i;
    end
  end

  // --------------------------------------------------------------------------
  // Raster counters and accumulators
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cx    <= '0;
      r_cy    <= '0;
      r_acc_x <= '0;
      r_acc_y <= '0;
      r_more  <= 1'b0;
    end else if (r_state == c_load) begin
      r_cx    <= '0;
      r_cy    <= '0;
      r_acc_x <= w_init_x;
      r_acc_y <= w_init_y;
      r_more  <= (r_dw != '0) && (r_dh != '0);
    end else if (w_adv) begin
      if (w_last_x) begin
        r_cx    <= '0;
        r_acc_x <= w_init_x;
        if (w_last_y) begin
          r_more <= 1'b0;
        end else begin
          r_cy    <= r_cy + 1'b1;
          r_acc_y <= r_acc_y + w_sy_ext;
        end
      end else begin
        r_cx    <= r_cx + 1'b1;
        r_acc_x <= r_acc_x + w_sx_ext;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output bundle register; holds while stalled by ready_i
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_valid <= 1'b0;
      r_destx <= '0;
      r_desty <= '0;
      r_srcx0 <= '0;
      r_srcx1 <= '0;
      r_srcy0 <= '0;
      r_srcy1 <= '0;
      r_fx    <= '0;
      r_fy    <= '0;
      r_sol   <= 1'b0;
      r_eof   <= 1'b0;
    end else if (w_adv) begin
      r_valid <= 1'b1;
      r_destx <= r_cx;
      r_desty <= r_cy;
      {r_srcx0, r_srcx1, r_fx} <= w_clx;
      {r_srcy0, r_srcy1, r_fy} <= w_cly;
      r_sol   <= (r_cx == '0);
      r_eof   <= w_last_x && w_last_y;
    end else if (ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign valid_o    = r_valid;
  assign busy_o     = w_busy;
  assign done_o     = w_done;
  assign destx_o    = r_destx;
  assign desty_o    = r_desty;
  assign srcx0_o    = r_srcx0;
  assign srcx1_o    = r_srcx1;
  assign srcy0_o    = r_srcy0;
  assign srcy1_o    = r_srcy1;
  assign srcx_fix_o = r_fx;
  assign srcy_fix_o = r_fy;
  assign sol_o      = r_sol;
  assign eof_o      = r_eof;

endmodule
`default_nettype wire

// File: doc/bilinear_coord_gen.md
Name: bilinear_coord_gen

Overview:
Frame-level source-coordinate generator for the bilinear scaler. It rasters the destination frame internally and produces, per destination pixel, the source integer indices of all four neighbours plus the fractional weights u and v. It replaces per-pixel multipliers with incremental accumulators, selects normal or centre-aligned mapping at run time, clamps neighbours to the source borders, and drives the pixel-fetch/weight stage over a valid/ready handshake.

Parameters:
INDEX_WIDTH, 11, bit width of destination and source pixel indices and of the size inputs.
INT_WIDTH, 8, integer bits of the scale factors; must be <= INDEX_WIDTH.
FIX_WIDTH, 12, fractional bits of scale factors, accumulators and weight outputs.

Ports:
clk_i  in  1  clock.
rst_n_i  in  1  asynchronous active-low reset.
start_i  in  1  frame start pulse; sampled only in IDLE.
align_mode_i  in  1  0 = normal (src = dst*s); 1 = centre-aligned (src = (dst+0.5)*s - 0.5); latched at start.
dest_width_i  in  INDEX_WIDTH  destination width in pixels; latched at start.
dest_height_i  in  INDEX_WIDTH  destination height in pixels; latched at start.
src_width_i  in  INDEX_WIDTH  source width in pixels; latched at start.
src_height_i  in  INDEX_WIDTH  source height in pixels; latched at start.
scale_factorx_i  in  INT_WIDTH+FIX_WIDTH  src_width/dest_width, unsigned fixed point; latched at start.
scale_factory_i  in  INT_WIDTH+FIX_WIDTH  src_height/dest_height, unsigned fixed point; latched at start.
ready_i  in  1  downstream accepts the current output.
valid_o  out  1  output bundle is valid.
busy_o  out  1  high from start acceptance until the done pulse (inclusive).
done_o  out  1  one-cycle pulse after the last pixel handshake.
destx_o  out  INDEX_WIDTH  destination x of the current bundle.
desty_o  out  INDEX_WIDTH  destination y of the current bundle.
srcx0_o  out  INDEX_WIDTH  left neighbour index.
srcx1_o  out  INDEX_WIDTH  right neighbour index.
srcy0_o  out  INDEX_WIDTH  top neighbour index.
srcy1_o  out  INDEX_WIDTH  bottom neighbour index.
srcx_fix_o  out  FIX_WIDTH  horizontal weight u.
srcy_fix_o  out  FIX_WIDTH  vertical weight v.
sol_o  out  1  bundle is the first pixel of a row.
eof_o  out  1  bundle is the last pixel of the frame.

Behaviour:
- Reset: all outputs 0; FSM enters IDLE; accumulators and counters cleared. Reset asserted mid-frame aborts the frame immediately, with no done pulse.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE -> LOAD on start_i. All config inputs are latched at that edge; busy_o rises.
- LOAD (1 cycle):
  - If the latched dest_width or dest_height is 0, go to DONE with no valid_o.
  - Otherwise initialise the accumulators: init = 0 in normal mode; init = (s>>1) - 2^(FIX_WIDTH-1) in centre mode. Then go to RUN.
- Accumulators: signed, INDEX_WIDTH+FIX_WIDTH+1 bits. The x accumulator adds sx per pixel and reloads init at row end. The y accumulator adds sy at row end.
- Output register load condition: (!valid_o || ready_i) in RUN with pixels remaining. This gives first valid_o 2 cycles after the start edge, then up to 1 bundle per cycle.
- Stall: while valid_o && !ready_i, every output holds stable.
- Clamp per axis, with acc = accumulator, n = source size:
  - acc < 0 -> idx0 = 0, idx1 = 0, fix = 0.
  - Else if acc[int] >= n-1 -> idx0 = idx1 = n-1, fix = 0.
  - Otherwise idx0 = acc[int], idx1 = idx0+1, fix = acc[FIX_WIDTH-1:0].
- Raster order: x increments fastest. sol_o is set when destx = 0. eof_o is set when destx = W-1 and desty = H-1.
- Frame end: the handshake with eof_o moves the FSM to DONE. valid_o drops next cycle unless ready_i was low.
- DONE (1 cycle): done_o = 1, then return to IDLE and drop busy_o.
- start_i is ignored outside IDLE.
- Caller guarantees dest*s < 2^INDEX_WIDTH; accumulator wrap behaviour is not required beyond that bound.

Test Plan:
- Normal, W=4, H=2, src 8x4, sx=sy=0x02000 -> srcx0 = 0, 2, 4, 6; srcx1 = 1, 3, 5, 7; fix 0; srcy0 = 0, 2; 8 bundles; sol on x=0; eof on the 8th; done 1 cycle later.
- Centre, same setup -> x = 0.5, 2.5, 4.5, 6.5: srcx0 = 0, 2, 4, 6; srcx_fix = 0x800; srcx1 = srcx0+1.
- Centre downscale-up, sx=0x00800 (0.5), W=4, src 2 -> acc -0.25 gives 0/0/fix 0; then 0.25 gives 0/1/0x400; then 0.75 gives 0/1/0xC00; then 1.25 gives 1/1/fix 0 (right-border clamp).
- Backpressure: hold ready_i low 5 cycles mid-row -> all outputs stable, no pixel skipped or duplicated, total bundle count = W*H.
- dest_width = 0 -> no valid_o; done_o pulses 2 cycles after start; busy_o falls after it.
- rst_n_i low during row 1, then a new start -> outputs 0 immediately, no done_o; the new frame begins at (0,0) with fresh config.
